// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the pipeline controller and the debug/decode side.
// The controller takes the slave modport; the debug unit and hazard sources take master.
interface pipeline_ctrl_if #(
    parameter int CNT_SIZE = 32
);
    logic                i_run;
    logic                i_step;
    logic [4:0]          i_id_rs;
    logic [4:0]          i_id_rt;
    logic                i_id_uses_rt;
    logic                i_id_halt;
    logic                i_id_jump;
    logic                i_idex_mem_to_reg;
    logic [4:0]          i_idex_rt;
    logic                o_pc_enable;
    logic                o_ifid_enable;
    logic                o_ifid_flush;
    logic                o_idex_enable;
    logic                o_idex_bubble;
    logic                o_exmem_enable;
    logic                o_memwb_enable;
    logic                o_halted;
    logic [15:0]         o_stall_count;
    logic [CNT_SIZE-1:0] o_cycle_count;

    modport master (
        output i_run, i_step, i_id_rs, i_id_rt, i_id_uses_rt, i_id_halt,
               i_id_jump, i_idex_mem_to_reg, i_idex_rt,
        input  o_pc_enable, o_ifid_enable, o_ifid_flush, o_idex_enable,
               o_idex_bubble, o_exmem_enable, o_memwb_enable, o_halted,
               o_stall_count, o_cycle_count
    );

    modport slave (
        input  i_run, i_step, i_id_rs, i_id_rt, i_id_uses_rt, i_id_halt,
               i_id_jump, i_idex_mem_to_reg, i_idex_rt,
        output o_pc_enable, o_ifid_enable, o_ifid_flush, o_idex_enable,
               o_idex_bubble, o_exmem_enable, o_memwb_enable, o_halted,
               o_stall_count, o_cycle_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/run controller for the 5-stage pipeline: load-use stalls, jump
// flushes, debug run/step and the HALT drain into a terminal halted state.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_SIZE     = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          drain_cnt_q, drain_cnt_d;
    logic                halted_q, halted_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic [CNT_SIZE-1:0] cycle_cnt_q, cycle_cnt_d;

    logic advance;
    logic hazard;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign advance = ((state_q == RUN) && bus.i_run) ||
                     ((state_q == IDLE) && bus.i_step);

    // A load in EX writing r0 never creates a dependency.
    assign hazard = advance && bus.i_idex_mem_to_reg && (bus.i_idex_rt != 5'd0) &&
                    ((bus.i_idex_rt == bus.i_id_rs) ||
                     (bus.i_id_uses_rt && (bus.i_idex_rt == bus.i_id_rt)));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;

        case (state_q)
            IDLE:    if (bus.i_run) state_d = RUN;
            RUN:     if (!bus.i_run) state_d = IDLE;
            DRAIN: begin
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                cycle_cnt_d = cycle_cnt_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
                if (drain_cnt_q == 4'd0) state_d = HALTED;
                else                     drain_cnt_d = drain_cnt_q - 4'd1;
            end
            default: state_d = HALTED;
        endcase

        if (advance) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            cycle_cnt_d = cycle_cnt_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
            // Stall wins over jump/halt; those are re-seen once the load retires.
            if (hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                stall_cnt_d = sat_inc16(stall_cnt_q);
            end else if (bus.i_id_halt) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                state_d     = DRAIN;
                drain_cnt_d = 4'(DRAIN_CYCLES - 1);
            end else if (bus.i_id_jump) begin
                ifid_flush  = 1'b1;
            end
        end

        halted_d = (state_d == HALTED);
    end

    // ---- control state registers ----
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= 4'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.o_pc_enable    = pc_en;
    assign bus.o_ifid_enable  = ifid_en;
    assign bus.o_ifid_flush   = ifid_flush;
    assign bus.o_idex_enable  = idex_en;
    assign bus.o_idex_bubble  = idex_bubble;
    assign bus.o_exmem_enable = exmem_en;
    assign bus.o_memwb_enable = memwb_en;
    assign bus.o_halted       = halted_q;
    assign bus.o_stall_count  = stall_cnt_q;
    assign bus.o_cycle_count  = cycle_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge, combinational
// outputs are sampled 1ns later and registered outputs 1ns after the rising edge.
module tb_pipeline_ctrl;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    pipeline_ctrl_if #(.CNT_SIZE(32)) bus ();

    pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_SIZE(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, ifid, idex, exmem, memwb}
    function automatic logic [4:0] ens();
        return {bus.o_pc_enable, bus.o_ifid_enable, bus.o_idex_enable,
                bus.o_exmem_enable, bus.o_memwb_enable};
    endfunction

    task automatic clear_inputs();
        bus.i_run = 0; bus.i_step = 0; bus.i_id_rs = 0; bus.i_id_rt = 0;
        bus.i_id_uses_rt = 0; bus.i_id_halt = 0; bus.i_id_jump = 0;
        bus.i_idex_mem_to_reg = 0; bus.i_idex_rt = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++; if (ens() !== 5'b00000) $display("FAIL reset_enables got=%b exp=00000", ens()); else passed++;
        total++; if ({bus.o_ifid_flush, bus.o_idex_bubble, bus.o_halted} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {bus.o_ifid_flush, bus.o_idex_bubble, bus.o_halted}); else passed++;
        total++; if (bus.o_stall_count !== 16'd0 || bus.o_cycle_count !== 32'd0)
            $display("FAIL reset_counts stall=%0d cyc=%0d exp=0/0", bus.o_stall_count, bus.o_cycle_count); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_step();
        bus.i_step = 1; #1;
        total++; if (ens() !== 5'b11111) $display("FAIL step_enables got=%b exp=11111", ens()); else passed++;
        next_cycle();
        total++; if (bus.o_cycle_count !== 32'd1) $display("FAIL step_cycle got=%0d exp=1", bus.o_cycle_count); else passed++;
        @(negedge clk); bus.i_step = 0; #1;
        total++; if (ens() !== 5'b00000) $display("FAIL step_after got=%b exp=00000", ens()); else passed++;
        next_cycle();
        total++; if (bus.o_cycle_count !== 32'd1) $display("FAIL step_hold got=%0d exp=1", bus.o_cycle_count); else passed++;
        @(negedge clk);
    endtask

    task automatic test_load_use();
        bus.i_run = 1; #1;
        total++; if (ens() !== 5'b00000) $display("FAIL idle_run_no_adv got=%b exp=00000", ens()); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_idex_mem_to_reg = 1; bus.i_idex_rt = 5; bus.i_id_rs = 5; #1;
        total++; if (ens() !== 5'b00111 || bus.o_idex_bubble !== 1'b1)
            $display("FAIL lu_stall ens=%b bub=%b exp=00111/1", ens(), bus.o_idex_bubble); else passed++;
        next_cycle();
        total++; if (bus.o_stall_count !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", bus.o_stall_count); else passed++;
        @(negedge clk); bus.i_idex_rt = 0; bus.i_id_rs = 0; #1;
        total++; if (ens() !== 5'b11111 || bus.o_idex_bubble !== 1'b0)
            $display("FAIL lu_r0 ens=%b bub=%b exp=11111/0", ens(), bus.o_idex_bubble); else passed++;
        next_cycle();
        total++; if (bus.o_stall_count !== 16'd1) $display("FAIL lu_r0_cnt got=%0d exp=1", bus.o_stall_count); else passed++;
        @(negedge clk);
    endtask

    task automatic test_uses_rt();
        bus.i_idex_mem_to_reg = 1; bus.i_idex_rt = 5; bus.i_id_rs = 0; bus.i_id_rt = 5;
        bus.i_id_uses_rt = 0; #1;
        total++; if (ens() !== 5'b11111 || bus.o_idex_bubble !== 1'b0)
            $display("FAIL rt_unused ens=%b bub=%b exp=11111/0", ens(), bus.o_idex_bubble); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_id_uses_rt = 1; #1;
        total++; if (ens() !== 5'b00111 || bus.o_idex_bubble !== 1'b1)
            $display("FAIL rt_used ens=%b bub=%b exp=00111/1", ens(), bus.o_idex_bubble); else passed++;
        next_cycle();
        total++; if (bus.o_stall_count !== 16'd2) $display("FAIL rt_used_cnt got=%0d exp=2", bus.o_stall_count); else passed++;
        @(negedge clk);
        bus.i_idex_mem_to_reg = 0; bus.i_id_uses_rt = 0; bus.i_idex_rt = 0; bus.i_id_rt = 0;
    endtask

    task automatic test_jump();
        bus.i_id_jump = 1; #1;
        total++; if (bus.o_ifid_flush !== 1'b1 || bus.o_pc_enable !== 1'b1)
            $display("FAIL jump_flush flush=%b pc=%b exp=1/1", bus.o_ifid_flush, bus.o_pc_enable); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_id_jump = 0; #1;
        total++; if (bus.o_ifid_flush !== 1'b0) $display("FAIL jump_once got=%b exp=0", bus.o_ifid_flush); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_id_jump = 1; bus.i_idex_mem_to_reg = 1; bus.i_idex_rt = 7; bus.i_id_rs = 7; #1;
        total++; if (bus.o_ifid_flush !== 1'b0 || bus.o_idex_bubble !== 1'b1 || bus.o_pc_enable !== 1'b0)
            $display("FAIL jump_vs_stall flush=%b bub=%b pc=%b exp=0/1/0",
                     bus.o_ifid_flush, bus.o_idex_bubble, bus.o_pc_enable); else passed++;
        next_cycle();
        total++; if (bus.o_stall_count !== 16'd3) $display("FAIL jump_stall_cnt got=%0d exp=3", bus.o_stall_count); else passed++;
        @(negedge clk);
        bus.i_id_jump = 0; bus.i_idex_mem_to_reg = 0; bus.i_idex_rt = 0; bus.i_id_rs = 0;
    endtask

    task automatic test_pause();
        bus.i_run = 0; #1;
        total++; if (ens() !== 5'b00000) $display("FAIL pause_enables got=%b exp=00000", ens()); else passed++;
        next_cycle();
        total++; if (bus.o_cycle_count !== 32'd8) $display("FAIL pause_cycle got=%0d exp=8", bus.o_cycle_count); else passed++;
        @(negedge clk); bus.i_run = 1;
        next_cycle(); @(negedge clk);
    endtask

    task automatic test_halt();
        bus.i_id_halt = 1; #1;
        total++; if (ens() !== 5'b00111 || bus.o_idex_bubble !== 1'b0)
            $display("FAIL halt_decode ens=%b bub=%b exp=00111/0", ens(), bus.o_idex_bubble); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_id_halt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (ens() !== 5'b00111 || bus.o_idex_bubble !== 1'b1 || bus.o_halted !== 1'b0)
                $display("FAIL drain_%0d ens=%b bub=%b halted=%b exp=00111/1/0",
                         i, ens(), bus.o_idex_bubble, bus.o_halted); else passed++;
            next_cycle(); @(negedge clk);
        end
        #1;
        total++; if (bus.o_halted !== 1'b1 || ens() !== 5'b00000 || bus.o_idex_bubble !== 1'b0)
            $display("FAIL halted_state halted=%b ens=%b bub=%b exp=1/00000/0",
                     bus.o_halted, ens(), bus.o_idex_bubble); else passed++;
        total++; if (bus.o_cycle_count !== 32'd13) $display("FAIL halt_cycle got=%0d exp=13", bus.o_cycle_count); else passed++;
        bus.i_run = 0; bus.i_step = 1; #1;
        total++; if (ens() !== 5'b00000) $display("FAIL halted_step got=%b exp=00000", ens()); else passed++;
        next_cycle(); @(negedge clk);
        bus.i_step = 0; bus.i_run = 1;
        next_cycle();
        total++; if (bus.o_halted !== 1'b1 || bus.o_cycle_count !== 32'd13)
            $display("FAIL halted_sticky halted=%b cyc=%0d exp=1/13", bus.o_halted, bus.o_cycle_count); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        rst = 1; #1;
        rst = 0; bus.i_run = 1;
        next_cycle(); @(negedge clk);
        bus.i_id_halt = 1;
        next_cycle(); @(negedge clk);
        bus.i_id_halt = 0;
        next_cycle(); @(negedge clk);
        #1;
        total++; if (bus.o_idex_bubble !== 1'b1 || bus.o_cycle_count !== 32'd2)
            $display("FAIL drain2_pre bub=%b cyc=%0d exp=1/2", bus.o_idex_bubble, bus.o_cycle_count); else passed++;
        rst = 1; #1;
        total++; if (ens() !== 5'b00000 || bus.o_halted !== 1'b0 || bus.o_cycle_count !== 32'd0)
            $display("FAIL drain_reset ens=%b halted=%b cyc=%0d exp=00000/0/0",
                     ens(), bus.o_halted, bus.o_cycle_count); else passed++;
        bus.i_run = 0;
        @(negedge clk); rst = 0;
        next_cycle();
        total++; if (ens() !== 5'b00000 || bus.o_idex_bubble !== 1'b0)
            $display("FAIL post_reset_idle ens=%b bub=%b exp=00000/0", ens(), bus.o_idex_bubble); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_step();
        test_load_use();
        test_uses_rt();
        test_jump();
        test_pause();
        test_halt();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush/run controller for the 5-stage pipeline.
- Consumes the control and register fields that the ID/EX register presents toward EX.
- Drives the enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the ID/EX bubble mux and the IF/ID flush.
- Sequences debug run, single-step and the HALT drain down to a halted state.

Parameters:
- DRAIN_CYCLES, 4, cycles after HALT decode before halting, so in-flight instructions retire through WB (legal range 1..15).
- CNT_SIZE, 32, width of the debug cycle counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_run  in  1  level; continuous execution request from the debug unit
- i_step  in  1  one-cycle pulse; advance the pipeline exactly one cycle
- i_id_rs  in  5  rs of the instruction in ID
- i_id_rt  in  5  rt of the instruction in ID
- i_id_uses_rt  in  1  instruction in ID reads rt (R-type, store, branch)
- i_id_halt  in  1  instruction in ID is HALT
- i_id_jump  in  1  jump/branch taken, resolved in ID
- i_idex_mem_to_reg  in  1  mem_to_reg field currently held in ID/EX (load in EX)
- i_idex_rt  in  5  rt field currently held in ID/EX (load destination)
- o_pc_enable  out  1  PC update enable
- o_ifid_enable  out  1  IF/ID enable
- o_ifid_flush  out  1  IF/ID clear (squash the fetched instruction)
- o_idex_enable  out  1  ID/EX enable
- o_idex_bubble  out  1  forces all ID/EX control inputs to zero (NOP)
- o_exmem_enable  out  1  EX/MEM enable
- o_memwb_enable  out  1  MEM/WB enable
- o_halted  out  1  registered; pipeline drained after HALT
- o_stall_count  out  16  registered; saturating count of load-use stall cycles
- o_cycle_count  out  CNT_SIZE  registered; count of advance cycles

Behaviour:
- FSM states: IDLE, RUN, DRAIN, HALTED. Reset enters IDLE with drain counter 0, o_halted=0, both counters 0.
- All enables, flush and bubble are combinational from state and inputs. In IDLE with i_step=0 they are all 0, so at reset every output is 0.
- Advance cycle: state RUN, or state IDLE with i_step=1.
  - o_idex_enable, o_exmem_enable and o_memwb_enable are 1.
  - o_pc_enable and o_ifid_enable are 1 unless overridden below.
- Load-use hazard, only on an advance cycle:
  - Condition: i_idex_mem_to_reg=1, i_idex_rt!=0, and (i_idex_rt==i_id_rs, or i_id_uses_rt=1 and i_idex_rt==i_id_rt).
  - Response: o_pc_enable=0, o_ifid_enable=0, o_idex_bubble=1.
  - Jump and halt in ID are ignored this cycle and re-evaluated after the stall.
- Jump: on an advance cycle with no hazard and i_id_jump=1, o_ifid_flush=1 for that cycle. PC stays enabled and loads the target.
- HALT: on an advance cycle with no hazard and i_id_halt=1:
  - o_pc_enable=0 and o_ifid_enable=0; HALT itself enters ID/EX.
  - Next state is DRAIN with the counter loaded to DRAIN_CYCLES-1.
  - Applies equally from a step in IDLE.
- DRAIN:
  - Enables: pc=0, ifid=0, idex/exmem/memwb=1, bubble=1. Advances regardless of i_run and i_step.
  - Counter decrements each cycle; when it reads 0, next state is HALTED.
- HALTED: every enable is 0 and o_halted=1. HALTED exits only by reset.
- Transitions:
  - IDLE goes to RUN when i_run=1.
  - RUN goes to IDLE when i_run=0. The pause takes effect the cycle i_run is low, with no advance that cycle.
  - A step pulse in IDLE advances one cycle and stays IDLE. i_step is ignored in RUN, DRAIN and HALTED.
  - If i_run=1 and i_step=1 in IDLE: treat as a step and move to RUN.
- o_stall_count increments on every hazard stall cycle and saturates at 16'hFFFF.
- o_cycle_count increments on every advance cycle and every DRAIN cycle, and wraps modulo 2^CNT_SIZE.
- Reset asserted mid-DRAIN or in HALTED returns immediately to IDLE with all counters cleared.

Test Plan:
- Reset, i_run=0 -> all enables 0, o_halted=0, counters 0. i_step for 1 cycle -> exactly one cycle with all five enables 1, and o_cycle_count=1.
- RUN, i_idex_mem_to_reg=1, i_idex_rt=5, i_id_rs=5 -> one cycle of pc/ifid=0 and bubble=1, with o_stall_count 0->1. Same stimulus with i_idex_rt=0 -> no stall.
- RUN, i_id_uses_rt=0, i_id_rt=5, i_idex_rt=5, load in EX -> no stall. Set i_id_uses_rt=1 -> stall.
- RUN, i_id_jump=1 for one cycle -> o_ifid_flush=1 that cycle only, pc_enable=1. Jump coincident with a hazard -> stall wins and flush=0.
- RUN, i_id_halt=1, DRAIN_CYCLES=4 -> 4 DRAIN cycles with bubble=1, then o_halted=1 and all enables 0. i_run toggling afterwards has no effect.
- Reset asserted on the 2nd DRAIN cycle -> state IDLE, o_halted=0, o_cycle_count=0.
